segre_dtlb_walker: RTL and testbench

- Responder for DTLB misses in the memory stage.
- Accepts a missing virtual address and reads the 32-bit page-table entry (PTE) from a single-level linear page table in memory.
- On a valid PTE, returns a one-cycle fill (vpage, ppage, mode) to the DTLB; on an invalid PTE, returns a fault.
- Handles one walk at a time; sits between the DTLB miss output and the data-memory arbiter.

---
 rtl/segre_dtlb_walker.sv | 143 ++++++++++++++
 tb/tb_segre_dtlb_walker.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/segre_dtlb_walker.sv
// Single-level page-table walker that services DTLB misses with one PTE read per walk.
// Optional response timeout is built when SEGRE_DTLB_WALKER_TIMEOUT_EN is defined.
module segre_dtlb_walker #(
    parameter int VIRT_PAGE_BITS = 20,
    parameter int PHYS_PAGE_BITS = 8,
    parameter int PHYS_ADDR_SIZE = 20,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clock_i,
    input  logic                      rst_i,
    input  logic [PHYS_ADDR_SIZE-1:0] ptbr_i,
    input  logic                      miss_valid_i,
    input  logic [31:0]               miss_vaddr_i,
    output logic                      miss_ready_o,
    input  logic                      flush_i,
    output logic                      mem_req_o,
    output logic [PHYS_ADDR_SIZE-1:0] mem_addr_o,
    input  logic                      mem_gnt_i,
    input  logic                      mem_rvalid_i,
    input  logic [31:0]               mem_rdata_i,
    output logic                      fill_valid_o,
    output logic [VIRT_PAGE_BITS-1:0] fill_vpage_o,
    output logic [PHYS_PAGE_BITS-1:0] fill_ppage_o,
    output logic [1:0]                fill_mode_o,
    output logic                      fault_o,
    output logic                      fault_timeout_o
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, DRAIN} state_t;

    state_t                    state, next_state;
    logic [VIRT_PAGE_BITS-1:0] vpage_q;
    logic [PHYS_ADDR_SIZE-1:0] addr_q;
    logic                      pte_v_q;
    logic                      timeout_hit;
    logic                      accept;
    logic                      capture;
    logic [VIRT_PAGE_BITS-1:0] miss_vpage;

    assign miss_vpage = miss_vaddr_i[31 -: VIRT_PAGE_BITS];
    assign accept     = (state == IDLE) && (next_state == REQ);
    assign capture    = (state != RESP) && (next_state == RESP);

`ifdef SEGRE_DTLB_WALKER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_q;

    always_ff @(posedge clock_i) begin
        if (rst_i) begin
            wait_cnt_q <= '0;
        end else if (state != WAIT) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end

    // Fires in the last allowed WAIT cycle if the response still has not shown up.
    assign timeout_hit = (state == WAIT) && !mem_rvalid_i &&
                         (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge clock_i) begin
        if (rst_i) begin
            state        <= IDLE;
            vpage_q      <= '0;
            addr_q       <= '0;
            pte_v_q      <= 1'b0;
            fill_vpage_o <= '0;
            fill_ppage_o <= '0;
            fill_mode_o  <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                vpage_q <= miss_vpage;
                addr_q  <= ptbr_i + PHYS_ADDR_SIZE'({miss_vpage, 2'b00});
            end
            // Fill data only moves on a valid PTE, so it holds between fills.
            if (capture) begin
                pte_v_q <= mem_rdata_i[0];
                if (mem_rdata_i[0]) begin
                    fill_vpage_o <= vpage_q;
                    fill_ppage_o <= mem_rdata_i[12 +: PHYS_PAGE_BITS];
                    fill_mode_o  <= mem_rdata_i[2:1];
                end
            end
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (miss_valid_i && !flush_i) next_state = REQ;
            end
            REQ: begin
                // A flush after grant must still swallow the response unless it is already here.
                if (flush_i) begin
                    if (mem_gnt_i && !mem_rvalid_i) next_state = DRAIN;
                    else                            next_state = IDLE;
                end else if (mem_gnt_i) begin
                    next_state = mem_rvalid_i ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (flush_i)           next_state = mem_rvalid_i ? IDLE : DRAIN;
                else if (mem_rvalid_i) next_state = RESP;
                else if (timeout_hit)  next_state = DRAIN;
            end
            RESP:  next_state = IDLE;
            DRAIN: begin
                if (mem_rvalid_i) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        miss_ready_o    = 1'b0;
        mem_req_o       = 1'b0;
        fill_valid_o    = 1'b0;
        fault_o         = 1'b0;
        fault_timeout_o = 1'b0;
        if (!rst_i) begin
            miss_ready_o    = (state == IDLE);
            mem_req_o       = (state == REQ);
            fill_valid_o    = (state == RESP) && pte_v_q;
            fault_timeout_o = timeout_hit && !flush_i;
            fault_o         = ((state == RESP) && !pte_v_q) || fault_timeout_o;
        end
    end

    assign mem_addr_o = addr_q;

    logic unused_bits;
    assign unused_bits = ^{mem_rdata_i[31:12+PHYS_PAGE_BITS], mem_rdata_i[11:3],
                           miss_vaddr_i[31-VIRT_PAGE_BITS:0]};

endmodule

// File: tb/tb_segre_dtlb_walker.sv
// Directed bench for segre_dtlb_walker: fills, faults, wrap, flushes, back-to-back and reset.
module tb_segre_dtlb_walker;

    logic        clock_i = 1'b0;
    logic        rst_i;
    logic [19:0] ptbr_i;
    logic        miss_valid_i;
    logic [31:0] miss_vaddr_i;
    logic        miss_ready_o;
    logic        flush_i;
    logic        mem_req_o;
    logic [19:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        fill_valid_o;
    logic [19:0] fill_vpage_o;
    logic [7:0]  fill_ppage_o;
    logic [1:0]  fill_mode_o;
    logic        fault_o;
    logic        fault_timeout_o;

    int checks = 0;
    int fails  = 0;

    always #5 clock_i = ~clock_i;

    segre_dtlb_walker #(.TIMEOUT_CYCLES(8)) dut (
        .clock_i(clock_i), .rst_i(rst_i), .ptbr_i(ptbr_i),
        .miss_valid_i(miss_valid_i), .miss_vaddr_i(miss_vaddr_i), .miss_ready_o(miss_ready_o),
        .flush_i(flush_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .fill_valid_o(fill_valid_o), .fill_vpage_o(fill_vpage_o), .fill_ppage_o(fill_ppage_o),
        .fill_mode_o(fill_mode_o), .fault_o(fault_o), .fault_timeout_o(fault_timeout_o)
    );

    // Advance one clock; outputs are sampled and inputs driven 1ns after the edge.
    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    // Present a miss in IDLE and let it be accepted; leaves the DUT in REQ.
    task automatic start_miss(input logic [31:0] va);
        miss_valid_i = 1'b1;
        miss_vaddr_i = va;
        tick();
        miss_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; ptbr_i = 20'h0; miss_valid_i = 1'b0; miss_vaddr_i = 32'h0;
        flush_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
        tick(); tick();
        checks++;
        if ({miss_ready_o, mem_req_o, mem_addr_o, fill_valid_o, fill_vpage_o, fill_ppage_o,
             fill_mode_o, fault_o, fault_timeout_o} !== 55'd0) begin
            fails++;
            $display("FAIL reset_outputs: ready=%b req=%b addr=%h fill=%b vp=%h pp=%h md=%b flt=%b to=%b, all must be 0",
                     miss_ready_o, mem_req_o, mem_addr_o, fill_valid_o, fill_vpage_o,
                     fill_ppage_o, fill_mode_o, fault_o, fault_timeout_o);
        end
        rst_i = 1'b0;
        tick();
        checks++;
        if (miss_ready_o !== 1'b1) begin
            fails++; $display("FAIL reset_release_ready: got %b expected 1", miss_ready_o);
        end
    endtask

    task automatic test_basic_fill();
        ptbr_i = 20'h10000;
        start_miss(32'h0000_3ABC);
        checks++;
        if ({mem_req_o, mem_addr_o, miss_ready_o} !== {1'b1, 20'h1000C, 1'b0}) begin
            fails++; $display("FAIL basic_req: req=%b addr=%h ready=%b expected 1/1000c/0",
                              mem_req_o, mem_addr_o, miss_ready_o);
        end
        mem_gnt_i = 1'b1; tick(); mem_gnt_i = 1'b0;
        checks++;
        if ({mem_req_o, fill_valid_o, fault_o} !== 3'b000) begin
            fails++; $display("FAIL basic_wait: req/fill/fault=%b expected 000",
                              {mem_req_o, fill_valid_o, fault_o});
        end
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0004_5003; tick(); mem_rvalid_i = 1'b0;
        checks++;
        if ({fill_valid_o, fill_vpage_o, fill_ppage_o, fill_mode_o, fault_o} !==
            {1'b1, 20'h00003, 8'h45, 2'b01, 1'b0}) begin
            fails++; $display("FAIL basic_fill: fill=%b vp=%h pp=%h md=%b flt=%b expected 1/00003/45/01/0",
                              fill_valid_o, fill_vpage_o, fill_ppage_o, fill_mode_o, fault_o);
        end
        tick();
        checks++;
        if ({fill_valid_o, miss_ready_o, fill_vpage_o, fill_ppage_o, fill_mode_o} !==
            {1'b0, 1'b1, 20'h00003, 8'h45, 2'b01}) begin
            fails++; $display("FAIL basic_after: fill=%b ready=%b vp=%h pp=%h md=%b expected 0/1/00003/45/01",
                              fill_valid_o, miss_ready_o, fill_vpage_o, fill_ppage_o, fill_mode_o);
        end
    endtask

    task automatic test_invalid_pte();
        start_miss(32'h0000_7123);
        mem_gnt_i = 1'b1; tick(); mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0004_5002; tick(); mem_rvalid_i = 1'b0;
        checks++;
        if ({fault_o, fault_timeout_o, fill_valid_o, fill_vpage_o} !== {3'b100, 20'h00003}) begin
            fails++; $display("FAIL invalid_fault: flt=%b to=%b fill=%b vp=%h expected 1/0/0/00003",
                              fault_o, fault_timeout_o, fill_valid_o, fill_vpage_o);
        end
        tick();
        checks++;
        if ({miss_ready_o, fault_o, fill_valid_o} !== 3'b100) begin
            fails++; $display("FAIL invalid_after: ready/flt/fill=%b expected 100",
                              {miss_ready_o, fault_o, fill_valid_o});
        end
    endtask

    task automatic test_wrap_delayed_grant();
        ptbr_i = 20'hFFFFC;
        start_miss(32'h0000_1000);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({mem_req_o, mem_addr_o} !== {1'b1, 20'h00000}) begin
                fails++; $display("FAIL wrap_req_hold[%0d]: req=%b addr=%h expected 1/00000",
                                  i, mem_req_o, mem_addr_o);
            end
            mem_gnt_i = (i == 3);
            tick();
        end
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h000A_B007; tick(); mem_rvalid_i = 1'b0;
        checks++;
        if ({fill_valid_o, fill_vpage_o, fill_ppage_o, fill_mode_o} !==
            {1'b1, 20'h00001, 8'hAB, 2'b11}) begin
            fails++; $display("FAIL wrap_fill: fill=%b vp=%h pp=%h md=%b expected 1/00001/ab/11",
                              fill_valid_o, fill_vpage_o, fill_ppage_o, fill_mode_o);
        end
        tick();
    endtask

    task automatic test_flush_wait();
        ptbr_i = 20'h10000;
        start_miss(32'h0000_4000);
        mem_gnt_i = 1'b1; tick(); mem_gnt_i = 1'b0;
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({miss_ready_o, mem_req_o, fill_valid_o, fault_o} !== 4'b0000) begin
                fails++; $display("FAIL flush_drain[%0d]: ready/req/fill/flt=%b expected 0000",
                                  i, {miss_ready_o, mem_req_o, fill_valid_o, fault_o});
            end
            tick();
        end
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0001_2001; tick(); mem_rvalid_i = 1'b0;
        checks++;
        if ({miss_ready_o, fill_valid_o, fault_o, fill_vpage_o, fill_ppage_o} !==
            {3'b100, 20'h00001, 8'hAB}) begin
            fails++; $display("FAIL flush_absorb: ready=%b fill=%b flt=%b vp=%h pp=%h expected 1/0/0/00001/ab",
                              miss_ready_o, fill_valid_o, fault_o, fill_vpage_o, fill_ppage_o);
        end
    endtask

    task automatic test_flush_req();
        start_miss(32'h0000_2000);
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        checks++;
        if ({mem_req_o, miss_ready_o} !== 2'b01) begin
            fails++; $display("FAIL flush_req: req=%b ready=%b expected 0/1", mem_req_o, miss_ready_o);
        end
        // A request coinciding with a flush in IDLE is dropped.
        miss_valid_i = 1'b1; flush_i = 1'b1; tick(); miss_valid_i = 1'b0; flush_i = 1'b0;
        checks++;
        if ({mem_req_o, miss_ready_o} !== 2'b01) begin
            fails++; $display("FAIL flush_idle_drop: req=%b ready=%b expected 0/1", mem_req_o, miss_ready_o);
        end
    endtask

    task automatic test_back_to_back();
        ptbr_i = 20'h10000;
        start_miss(32'h0000_5000);
        miss_valid_i = 1'b1; miss_vaddr_i = 32'h0000_9000;
        mem_gnt_i = 1'b1; tick(); mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0001_1001; tick(); mem_rvalid_i = 1'b0;
        checks++;
        if ({fill_valid_o, fill_vpage_o, fill_ppage_o, miss_ready_o} !== {1'b1, 20'h00005, 8'h11, 1'b0}) begin
            fails++; $display("FAIL b2b_first: fill=%b vp=%h pp=%h ready=%b expected 1/00005/11/0",
                              fill_valid_o, fill_vpage_o, fill_ppage_o, miss_ready_o);
        end
        tick();
        checks++;
        if (miss_ready_o !== 1'b1) begin
            fails++; $display("FAIL b2b_idle_ready: got %b expected 1", miss_ready_o);
        end
        tick();
        miss_valid_i = 1'b0;
        checks++;
        if ({mem_req_o, mem_addr_o} !== {1'b1, 20'h10024}) begin
            fails++; $display("FAIL b2b_second_req: req=%b addr=%h expected 1/10024", mem_req_o, mem_addr_o);
        end
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0002_2005; tick();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        checks++;
        if ({fill_valid_o, fill_vpage_o, fill_ppage_o, fill_mode_o} !== {1'b1, 20'h00009, 8'h22, 2'b10}) begin
            fails++; $display("FAIL b2b_second_fill: fill=%b vp=%h pp=%h md=%b expected 1/00009/22/10",
                              fill_valid_o, fill_vpage_o, fill_ppage_o, fill_mode_o);
        end
        tick();
    endtask

    task automatic test_reset_mid_walk();
        start_miss(32'h0000_6000);
        mem_gnt_i = 1'b1; tick(); mem_gnt_i = 1'b0;
        rst_i = 1'b1; tick();
        checks++;
        if ({miss_ready_o, mem_addr_o, fill_vpage_o} !== 41'd0) begin
            fails++; $display("FAIL midwalk_reset: ready=%b addr=%h vp=%h expected 0/00000/00000",
                              miss_ready_o, mem_addr_o, fill_vpage_o);
        end
        rst_i = 1'b0; tick();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0003_3001; tick(); mem_rvalid_i = 1'b0;
        checks++;
        if ({miss_ready_o, fill_valid_o, fault_o} !== 3'b100) begin
            fails++; $display("FAIL midwalk_late_rvalid: ready/fill/flt=%b expected 100",
                              {miss_ready_o, fill_valid_o, fault_o});
        end
    endtask

`ifdef SEGRE_DTLB_WALKER_TIMEOUT_EN
    task automatic test_timeout();
        start_miss(32'h0000_1000);
        mem_gnt_i = 1'b1; tick(); mem_gnt_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (fault_o !== 1'b0) begin
                fails++; $display("FAIL timeout_early[%0d]: fault=%b expected 0", i, fault_o);
            end
            tick();
        end
        checks++;
        if ({fault_o, fault_timeout_o, fill_valid_o} !== 3'b110) begin
            fails++; $display("FAIL timeout_fault: flt/to/fill=%b expected 110",
                              {fault_o, fault_timeout_o, fill_valid_o});
        end
        tick();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0004_4001; tick(); mem_rvalid_i = 1'b0;
        checks++;
        if ({miss_ready_o, fill_valid_o, fault_o} !== 3'b100) begin
            fails++; $display("FAIL timeout_drain: ready/fill/flt=%b expected 100",
                              {miss_ready_o, fill_valid_o, fault_o});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_fill();
        test_invalid_pte();
        test_wrap_delayed_grant();
        test_flush_wait();
        test_flush_req();
        test_back_to_back();
        test_reset_mid_walk();
`ifdef SEGRE_DTLB_WALKER_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
